// File: rtl/cuca1_mem.sv
// rtl/cuca1_mem.sv - bus-attached word memory with MAR, 2-cycle reads and sticky error
//
// Optional feature macro: CUCA1_MEM_AUTOINC_EN
//   When defined, MAR advances by one (mod 2^BITW) on the edge that leaves
//   RD_DRIVE or WR_DONE; a mar_wr in that same cycle wins over the increment.
//
// Ports:
//   clock    in   1     single rising-edge clock
//   reset    in   1     synchronous active-high reset
//   bus_in   in   BITW  value on the shared CPU bus
//   bus_out  out  BITW  read data towards the bus (0 unless bus_oe)
//   bus_oe   out  1     memory owns the bus this cycle
//   mar_wr   in   1     load MAR from bus_in
//   mem_rd   in   1     read request at MAR
//   mem_wr   in   1     write request of bus_in at MAR
//   ready    out  1     one-cycle completion pulse
//   err      out  1     sticky error (conflicting request or MAR out of range)

module cuca1_mem #(
    parameter int BITW  = 8,
    parameter int DEPTH = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [BITW-1:0] bus_in,
    output logic [BITW-1:0] bus_out,
    output logic            bus_oe,
    input  logic            mar_wr,
    input  logic            mem_rd,
    input  logic            mem_wr,
    output logic            ready,
    output logic            err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // DEPTH may equal 2^BITW, so the range compare needs one extra bit.
    localparam logic [BITW:0] DEPTH_W = (BITW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_ACCESS = 2'd1,
        RD_DRIVE  = 2'd2,
        WR_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [BITW-1:0] r_mar;
    logic [BITW-1:0] r_rdata;
    logic            r_err;
    logic [BITW-1:0] r_mem [DEPTH];

    logic            w_oor;
    logic [AW-1:0]   w_idx;
    logic [BITW-1:0] w_rd_word;
    logic            w_rd_start;
    logic            w_wr_start;
    logic            w_conflict;
    logic            w_bus_oe;
    logic            w_ready;

    assign w_oor     = ({1'b0, r_mar} >= DEPTH_W);
    assign w_idx     = r_mar[AW-1:0];
    assign w_rd_word = w_oor ? '0 : r_mem[w_idx];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Requests are only decoded in IDLE; any other state ignores them.
    always_comb begin
        w_next     = r_state;
        w_rd_start = 1'b0;
        w_wr_start = 1'b0;
        w_conflict = 1'b0;
        w_bus_oe   = 1'b0;
        w_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_rd && mem_wr) begin
                    w_conflict = 1'b1;
                end else if (mem_rd) begin
                    w_rd_start = 1'b1;
                    w_next     = RD_ACCESS;
                end else if (mem_wr) begin
                    w_wr_start = 1'b1;
                    w_next     = WR_DONE;
                end
            end
            RD_ACCESS: begin
                w_next = RD_DRIVE;
            end
            RD_DRIVE: begin
                w_bus_oe = 1'b1;
                w_ready  = 1'b1;
                w_next   = IDLE;
            end
            WR_DONE: begin
                w_ready = 1'b1;
                w_next  = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Array has no reset so committed writes survive a reset.
    always_ff @(posedge clock) begin
        if (!reset && w_wr_start && !w_oor) begin
            r_mem[w_idx] <= bus_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_rd_start) begin
            r_rdata <= w_rd_word;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_conflict || ((w_rd_start || w_wr_start) && w_oor)) begin
            r_err <= 1'b1;
        end
    end

    // Requests in the same cycle as mar_wr see the old MAR because the
    // decode above uses r_mar, which only changes at this edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mar <= '0;
        end else if (mar_wr) begin
            r_mar <= bus_in;
        end
`ifdef CUCA1_MEM_AUTOINC_EN
        else if (r_state == RD_DRIVE || r_state == WR_DONE) begin
            r_mar <= r_mar + BITW'(1);
        end
`endif
    end

    assign bus_oe  = w_bus_oe;
    assign ready   = w_ready;
    assign bus_out = w_bus_oe ? r_rdata : '0;
    assign err     = r_err;

endmodule

// File: doc/cuca1_mem.md
CUCA1_MEM -- requirements
Module: cuca1_mem

Interface
REQ-001 SHALL have parameter BITW, default 8: width of bus words and of the memory address register (MAR).
REQ-002 SHALL have parameter DEPTH, default 16: number of storage words; legal range 1..2^BITW.
REQ-003 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port bus_in, input, BITW: the value currently on the shared CPU bus.
REQ-006 SHALL have port bus_out, output, BITW: the read data driven towards the bus.
REQ-007 SHALL have port bus_oe, output, 1: bus_out is valid and the memory owns the bus this cycle.
REQ-008 SHALL have port mar_wr, input, 1: load MAR from bus_in.
REQ-009 SHALL have port mem_rd, input, 1: read request at MAR.
REQ-010 SHALL have port mem_wr, input, 1: write request of bus_in at MAR.
REQ-011 SHALL have port ready, output, 1: single-cycle pulse marking completion of an access.
REQ-012 SHALL have port err, output, 1: sticky error flag.

Function
REQ-013 SHALL implement an FSM with states IDLE, RD_ACCESS, RD_DRIVE and WR_DONE.
REQ-014 SHALL, in any state, load MAR with bus_in at the clock edge when mar_wr=1; a request in the same cycle SHALL use the old MAR.
REQ-015 SHALL, in IDLE with mem_rd=1 and mem_wr=0, go to RD_ACCESS and capture the array word at MAR into an output register.
REQ-016 SHALL, in RD_ACCESS, go to RD_DRIVE unconditionally.
REQ-017 SHALL, in RD_DRIVE, assert bus_oe=1 and ready=1 with bus_out = captured word, then return to IDLE.
REQ-018 SHALL therefore give a read latency of exactly 2 cycles: data is on the bus in the second cycle after mem_rd is sampled.
REQ-019 SHALL, in IDLE with mem_wr=1 and mem_rd=0, write bus_in to the array at MAR at that edge and go to WR_DONE.
REQ-020 SHALL, in WR_DONE, assert ready=1 for one cycle with bus_oe=0, then return to IDLE.
REQ-021 SHALL ignore mem_rd and mem_wr in any non-IDLE state: no queuing and no error.
REQ-022 SHALL, in IDLE with mem_rd=1 and mem_wr=1, perform no access, set err, and stay in IDLE.
REQ-023 SHALL treat MAR >= DEPTH as out of range: a read returns 0 with normal timing, a write is discarded with normal timing, and err is set.
REQ-024 SHALL hold bus_out=0 whenever bus_oe=0.
REQ-025 SHALL keep err set until reset.
REQ-026 SHALL never assert bus_oe and ready outside RD_DRIVE/WR_DONE.

Reset
REQ-027 SHALL, on reset=1 at a clock edge, set state=IDLE, MAR=0, bus_out=0, bus_oe=0, ready=0 and err=0.
REQ-028 SHALL, on reset mid-access, abort the access: a pending read is not driven and a WR_DONE ready is not issued.
REQ-029 SHALL not clear array contents on reset; a write already committed in IDLE remains.
REQ-030 SHALL give reset priority over mar_wr, mem_rd and mem_wr in the same cycle.

Configuration
REQ-031 SHALL, with macro CUCA1_MEM_AUTOINC_EN defined, increment MAR by 1 modulo 2^BITW on the edge leaving RD_DRIVE or WR_DONE.
REQ-032 SHALL, with CUCA1_MEM_AUTOINC_EN defined, let mar_wr in that same cycle take priority over the increment.
REQ-033 SHALL, without CUCA1_MEM_AUTOINC_EN, change MAR only via mar_wr or reset.

Verification (BITW=8, DEPTH=16)
REQ-034 SHALL cover a write then read: mar_wr with bus_in=0x05, mem_wr with bus_in=0xA7 -> ready on the next cycle; mem_rd -> bus_oe=1, bus_out=0xA7 and ready=1 exactly 2 cycles later, err=0.
REQ-035 SHALL cover an out-of-range read: MAR=0x10, mem_rd -> bus_out=0x00, bus_oe=1 at +2, err=1 and err stays 1 after further legal accesses.
REQ-036 SHALL cover simultaneous requests: mem_rd=mem_wr=1 in IDLE -> no ready, no bus_oe, err=1, array at MAR unchanged.
REQ-037 SHALL cover reset mid-read: mem_rd, then reset=1 in RD_ACCESS -> bus_oe never asserted, and MAR=0, err=0, state IDLE the following cycle.
REQ-038 SHALL cover a request while busy: mem_wr with bus_in=0x33 during RD_ACCESS -> ignored, array unchanged, read completes normally.
REQ-039 SHALL cover auto-increment wrap with CUCA1_MEM_AUTOINC_EN defined: MAR=0xFF, read completes -> MAR=0x00; without the macro, MAR stays 0xFF.
